conv2_maxpool_relu: RTL

Downstream stage of the 2nd-convolution channel calculators. It consumes one channel's raster-ordered stream of 14-bit signed convolution sums (8x8 map per frame). It applies 2x2 stride-2 max pooling followed by ReLU and saturation. It emits a 4x4 map of 12-bit non-negative values to the flatten/fully-connected stage, and one instance is used per conv2 output channel.

---
 rtl/conv2_maxpool_relu.sv | 104 ++++++++++
 1 files changed

// File: rtl/conv2_maxpool_relu.sv
// conv2_maxpool_relu: 2x2 stride-2 max pooling, then ReLU and saturation,
// over one channel's raster-ordered stream of signed conv2 sums.
// The horizontal max of each pair is formed on odd columns. Even rows park
// it in a half-width line buffer. Odd rows combine it with the parked value
// and emit one registered result per 2x2 window.
module conv2_maxpool_relu #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0]        pool_out,
  output logic                    valid_out,
  output logic                    frame_done
);

  // Counter widths assume IMG_W >= 4 and IMG_H >= 2, both even.
  localparam int CW = $clog2(IMG_W);
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);

  logic [CW-1:0]          col_reg;
  logic [RW-1:0]          row_reg;
  logic signed [IN_W-1:0] h_reg;
  logic [OUT_W-1:0]       pool_reg;
  logic                   valid_reg;
  logic                   done_reg;

  // Half-width line buffer holding the horizontal maxima of the even row.
  // It needs no reset because each entry is written before it is read.
  logic signed [IN_W-1:0] line_buf [IMG_W/2];

  logic [CW-2:0]          buf_idx;
  logic signed [IN_W-1:0] hmax;
  logic signed [IN_W-1:0] buf_rd;
  logic signed [IN_W-1:0] win_max;
  logic [OUT_W-1:0]       relu_next;
  logic                   win_done;
  logic                   last_win;

  // Window maximum, ReLU clamp and saturation for the current sample.
  always_comb begin
    buf_idx   = col_reg[CW-1:1];
    hmax      = (data_in > h_reg) ? data_in : h_reg;
    buf_rd    = line_buf[buf_idx];
    win_max   = (buf_rd > hmax) ? buf_rd : hmax;
    relu_next = '0;
    if (win_max < 0)
      relu_next = '0;
    else if (win_max > SAT_MAX)
      relu_next = SAT_MAX[OUT_W-1:0];
    else
      relu_next = win_max[OUT_W-1:0];
    win_done  = valid_in && col_reg[0] && row_reg[0];
    last_win  = win_done && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
  end

  // Raster counters, horizontal hold and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg   <= '0;
      row_reg   <= '0;
      h_reg     <= '0;
      pool_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      if (valid_in) begin
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
        if (!col_reg[0])
          h_reg <= data_in;
      end
      if (win_done) begin
        pool_reg  <= relu_next;
        valid_reg <= 1'b1;
        done_reg  <= last_win;
      end
    end
  end

  // Even rows store the horizontal max of each column pair.
  always_ff @(posedge clk) begin
    if (rst_n && valid_in && col_reg[0] && !row_reg[0])
      line_buf[buf_idx] <= hmax;
  end

  assign pool_out   = pool_reg;
  assign valid_out  = valid_reg;
  assign frame_done = done_reg;

endmodule
